// File: rtl/result_shift_tx.sv
// Transmit side of the worker result interface: latches a result word on load and
// presents it LSB-byte first, advancing on each synchronized rising edge of the host shift pin.
module result_shift_tx #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       internal_clock,
    input  logic                       reset,
    input  logic                       i_load,
    input  logic [WIDTH-1:0]           i_result,
    input  logic                       i_shift_async,
    output logic [7:0]                 o_data_out,
    output logic                       o_valid,
    output logic [((WIDTH/8) > 1 ? $clog2(WIDTH/8) : 1)-1:0] o_byte_idx,
    output logic                       o_overrun
);

    localparam int NBYTES = WIDTH / 8;
    localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_shreg;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                 r_prev;

    logic                 w_syncOut;
    logic                 w_edge;
    logic                 w_lastByte;
    logic [WIDTH-1:0]     w_shregNext;

    assign w_syncOut   = r_sync[SYNC_STAGES-1];
    assign w_edge      = w_syncOut & ~r_prev;
    assign w_lastByte  = (o_byte_idx == IDXW'(NBYTES - 1));
    assign w_shregNext = r_shreg >> 8;

    // The shift pin is asynchronous to whichever clock was selected upstream.
    always_ff @(posedge internal_clock) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_shift_async};
            r_prev <= w_syncOut;
        end
    end

    always_ff @(posedge internal_clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            o_data_out <= '0;
            o_valid    <= 1'b0;
            o_byte_idx <= '0;
            o_overrun  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_load) begin
                        r_state    <= ACTIVE;
                        r_shreg    <= i_result;
                        o_data_out <= i_result[7:0];
                        o_valid    <= 1'b1;
                        o_byte_idx <= '0;
                    end
                end
                ACTIVE: begin
                    if (w_edge && w_lastByte) begin
                        // A load coinciding with the final edge chains straight into the next word.
                        if (i_load) begin
                            r_shreg    <= i_result;
                            o_data_out <= i_result[7:0];
                            o_valid    <= 1'b1;
                            o_byte_idx <= '0;
                        end else begin
                            r_state    <= IDLE;
                            r_shreg    <= '0;
                            o_data_out <= '0;
                            o_valid    <= 1'b0;
                            o_byte_idx <= '0;
                        end
                    end else begin
                        if (w_edge) begin
                            r_shreg    <= w_shregNext;
                            o_data_out <= w_shregNext[7:0];
                            o_byte_idx <= o_byte_idx + 1'b1;
                        end
                        if (i_load) begin
                            o_overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_shreg    <= '0;
                    o_data_out <= '0;
                    o_valid    <= 1'b0;
                    o_byte_idx <= '0;
                end
            endcase
        end
    end

endmodule
